// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forward selects,
// the EX/MEM control bundle and the default datapath width.
package execute_cycle_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } exmem_ctrl_t;

  // Code 11 is unused and falls back to the register-file operand.
  function automatic logic [1:0] fwd_normalize(input logic [1:0] sel);
    return (sel == 2'b11) ? FWD_RF : sel;
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage; add/sub wrap and there is no
// overflow flag, only Zero.
module alu
  import execute_cycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  logic [4:0] shamt;
  logic       less_than;
  alu_op_e    op;

  assign shamt     = SrcB[4:0];
  assign less_than = ($signed(SrcA) < $signed(SrcB));
  assign op        = alu_op_e'(ALUControl);

  always_comb begin
    Result = '0;
    case (op)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_XOR: Result = SrcA ^ SrcB;
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, less_than};
      ALU_SLL: Result = SrcA << shamt;
      ALU_SRL: Result = SrcA >> shamt;
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch target/redirect and the
// EX/MEM pipeline register.
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             ALUSrcE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic [1:0]       ResultSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] Imm_Ext_E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [4:0]       RD_E,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       RD_M,
  output logic [WIDTH-1:0] ALU_ResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] PCPlus4M
);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  exmem_ctrl_t      ctrl_e;
  exmem_ctrl_t      ctrl_m;

  // Forwarding from M uses the registered result, so a dependent op issued
  // the very next cycle sees its producer's value.
  always_comb begin
    src_a = RD1_E;
    case (fwd_normalize(ForwardA_E))
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (fwd_normalize(ForwardB_E))
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu #(.WIDTH(WIDTH)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = (BranchE & alu_zero) | JumpE;

  assign ctrl_e = '{reg_write:  RegWriteE,
                    mem_write:  MemWriteE,
                    result_src: ResultSrcE,
                    rd:         RD_E};

  // Store data is the forwarded B operand, never the immediate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_m      <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else begin
      ctrl_m      <= ctrl_e;
      ALU_ResultM <= alu_result;
      WriteDataM  <= fwd_b;
      PCPlus4M    <= PCPlus4E;
    end
  end

  assign RegWriteM  = ctrl_m.reg_write;
  assign MemWriteM  = ctrl_m.mem_write;
  assign ResultSrcM = ctrl_m.result_src;
  assign RD_M       = ctrl_m.rd;

endmodule
